cluster_periph_demux: RTL and testbench
=======================================

Name: cluster_periph_demux

Overview:
- Sits directly upstream of the cluster peripherals, on the slave side of the peripheral interconnect.
- Decodes one master-port request, by address window, onto one of NB_SLAVES peripheral ports. The port order follows the cluster peripheral ID map: EOC=0, TIMER=1, EU=2/3, HWPE=4, ICACHE_CTRL=5, DMA_CL=6, DMA_FC=7, DECOMP=8, EXT=9.
- Steers responses back to the master in request order.
- Unmapped or grounded targets are answered by an internal error slave.

Parameters:
- NB_SLAVES, 10, number of peripheral ports; decoded index >= NB_SLAVES selects the error slave.
- ID_WIDTH, 5, transaction ID width.
- ADDR_LSB, 10, LSB of the index field in add_i (1 KiB windows).
- ADDR_MSB, 13, MSB of the index field.
- MAX_OUTSTANDING, 4, maximum granted-but-unanswered requests (>=1).
- DECOMP_IDX, 8, index of the optional decompressor port.
- DECOMP_EN, 0, 0 = DECOMP_IDX is routed to the error slave.
- ERR_RDATA, 32'hBADACCE5, read data returned by the error slave.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  master request
- add_i  in  32  address
- wen_i  in  1  1 = read, 0 = write
- wdata_i  in  32  write data
- be_i  in  4  byte enables
- id_i  in  ID_WIDTH  transaction ID
- gnt_o  out  1  grant
- r_valid_o  out  1  response valid
- r_opc_o  out  1  response error flag
- r_rdata_o  out  32  response data
- r_id_o  out  ID_WIDTH  response ID
- per_req_o  out  NB_SLAVES  one-hot request per port
- per_add_o, per_wen_o, per_wdata_o, per_be_o, per_id_o  out  (as master)  broadcast to all ports
- per_gnt_i  in  NB_SLAVES  per-port grant
- per_r_valid_i  in  NB_SLAVES  per-port response valid
- per_r_opc_i  in  NB_SLAVES  per-port error flag
- per_r_rdata_i  in  NB_SLAVES*32  flattened read data, port k at [32k+31:32k]
- per_r_id_i  in  NB_SLAVES*ID_WIDTH  flattened response IDs
- spurious_o  out  1  sticky: response received from a non-current port

Behaviour:
- Decode: idx = add_i[ADDR_MSB:ADDR_LSB].
  - tgt = ERR if idx >= NB_SLAVES, or if idx == DECOMP_IDX and DECOMP_EN == 0.
  - Otherwise tgt = idx.
- State:
  - cnt, outstanding count, range 0..MAX_OUTSTANDING.
  - cur_tgt, target of the outstanding requests.
  - err_pend, err_id: registered error response.
  - spurious_o.
- Admission: accept = (cnt == 0) || (tgt == cur_tgt && cnt < MAX_OUTSTANDING). This single-target rule guarantees in-order responses.
- Request path, all combinational in the same cycle:
  - per_req_o[tgt] = req_i & accept when tgt is a port; all other bits 0.
  - gnt_o = per_gnt_i[tgt] & accept for a port target.
  - gnt_o = req_i & accept for ERR; the error slave always grants.
  - Broadcast signals are wired straight through.
- Handshake on grant (req_i & gnt_o):
  - cur_tgt <= tgt and cnt increments.
  - For an ERR grant: err_pend <= 1 and err_id <= id_i.
- Response path, combinational:
  - If cur_tgt is a port: r_valid_o = per_r_valid_i[cur_tgt], and r_opc/rdata/id come from that port.
  - If cur_tgt is ERR: r_valid_o = err_pend, r_opc_o = 1, r_rdata_o = ERR_RDATA, r_id_o = err_id; err_pend clears the cycle after.
  - When r_valid_o is low, r_rdata_o/r_id_o/r_opc_o = 0.
- Error slave latency: response exactly 1 cycle after grant. Back-to-back ERR grants give r_valid_o high on consecutive cycles.
- cnt update: +1 on grant, -1 on r_valid_o, unchanged when both occur in the same cycle. cnt never wraps.
- cnt == MAX_OUTSTANDING: gnt_o stays 0 (no increment) until a response retires.
- per_r_valid_i[k] with k != cur_tgt, or any response when cnt == 0:
  - Ignored; not forwarded.
  - spurious_o set to 1 and held until reset.
- Target switch: a request to a different tgt stalls until cnt == 0. It can be granted in the same cycle the last response retires, because accept uses cnt after the decrement is applied.
- Reset, asynchronous and also valid mid-transaction:
  - cnt = 0, cur_tgt = 0, err_pend = 0, err_id = 0, spurious_o = 0.
  - Hence gnt_o, r_valid_o, r_opc_o, r_rdata_o, r_id_o, per_req_o all 0 while req_i = 0.
  - In-flight responses arriving after reset count as spurious.

Test Plan:
- Timer access:
  - Stimulus: read at add 0x400, id 3, per_gnt_i[1] = 1; 2 cycles later per_r_valid_i[1] = 1, rdata 0x1234.
  - Response: per_req_o = 0b0000000010, gnt_o = 1 same cycle; r_valid_o = 1, r_rdata_o = 0x1234, r_id_o = 3; cnt 1 -> 0.
- Unmapped and grounded targets:
  - Stimulus: add 0x2800 (idx 10), id 7; then add 0x2000 (idx 8, DECOMP_EN = 0).
  - Response: per_req_o = 0 and gnt_o = 1 each time; next cycle r_valid_o = 1, r_opc_o = 1, rdata = 0xBADACCE5, r_id_o = 7.
- Outstanding limit:
  - Stimulus: 5 back-to-back reads to EOC (0x000), port always granting, no responses.
  - Response: 4 grants, 5th gnt_o = 0; after one per_r_valid_i[0] pulse, 5th grant occurs that cycle with cnt staying at 4.
- Target switch:
  - Stimulus: 2 outstanding to DMA_CL (0x1800), then a request to HWPE (0x1000).
  - Response: HWPE stalled (gnt_o = 0); granted in the cycle the 2nd DMA_CL response returns; no response reordering.
- Spurious response:
  - Stimulus: per_r_valid_i[5] = 1 with cnt == 0.
  - Response: r_valid_o = 0, spurious_o = 1 and held.
- Reset:
  - Stimulus: rst_ni low while cnt = 3.
  - Response: all outputs 0 immediately; after release the first request to any target is granted.

Source files
------------

// File: rtl/cluster_periph_demux.sv
// Cluster peripheral demultiplexer.
// Routes one master request by address window to a peripheral port.
// Only one target may have requests in flight at a time, so responses
// always come back to the master in request order. Unmapped windows, and
// the decompressor window when it is not present, are answered by an
// internal error slave one cycle after grant.
module cluster_periph_demux #(
    parameter int          NB_SLAVES       = 10,
    parameter int          ID_WIDTH        = 5,
    parameter int          ADDR_LSB        = 10,
    parameter int          ADDR_MSB        = 13,
    parameter int          MAX_OUTSTANDING = 4,
    parameter int          DECOMP_IDX      = 8,
    parameter int          DECOMP_EN       = 0,
    parameter logic [31:0] ERR_RDATA       = 32'hBADACCE5
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    // master side
    input  logic                            req_i,
    input  logic [31:0]                     add_i,
    input  logic                            wen_i,
    input  logic [31:0]                     wdata_i,
    input  logic [3:0]                      be_i,
    input  logic [ID_WIDTH-1:0]             id_i,
    output logic                            gnt_o,
    output logic                            r_valid_o,
    output logic                            r_opc_o,
    output logic [31:0]                     r_rdata_o,
    output logic [ID_WIDTH-1:0]             r_id_o,
    // peripheral side
    output logic [NB_SLAVES-1:0]            per_req_o,
    output logic [31:0]                     per_add_o,
    output logic                            per_wen_o,
    output logic [31:0]                     per_wdata_o,
    output logic [3:0]                      per_be_o,
    output logic [ID_WIDTH-1:0]             per_id_o,
    input  logic [NB_SLAVES-1:0]            per_gnt_i,
    input  logic [NB_SLAVES-1:0]            per_r_valid_i,
    input  logic [NB_SLAVES-1:0]            per_r_opc_i,
    input  logic [NB_SLAVES*32-1:0]         per_r_rdata_i,
    input  logic [NB_SLAVES*ID_WIDTH-1:0]   per_r_id_i,
    output logic                            spurious_o
);

    localparam int IDX_W = ADDR_MSB - ADDR_LSB + 1;
    localparam int TGT_W = $clog2(NB_SLAVES + 1);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // The error slave takes the code just past the last real port.
    localparam logic [TGT_W-1:0] ERR_TGT = TGT_W'(NB_SLAVES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [IDX_W-1:0]     idx;
    logic [TGT_W-1:0]     tgt;
    logic                 tgt_is_port;
    logic [TGT_W-1:0]     cur_tgt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_eff;
    logic                 accept;
    logic                 handshake;
    logic                 err_pend;
    logic [ID_WIDTH-1:0]  err_id;
    logic [NB_SLAVES-1:0] fwd_mask;
    logic                 spurious_evt;

    // Broadcast request fields; only per_req_o is target-specific.
    assign per_add_o   = add_i;
    assign per_wen_o   = wen_i;
    assign per_wdata_o = wdata_i;
    assign per_be_o    = be_i;
    assign per_id_o    = id_i;

    // Address window decode, folding unmapped and absent ports onto ERR.
    always_comb begin
        // NOTE: every variable gets a default at the top of a combinational
        // block so that no path leaves it unassigned and infers a latch.
        idx = add_i[ADDR_MSB:ADDR_LSB];
        tgt = ERR_TGT;
        if (int'(idx) < NB_SLAVES &&
            !(DECOMP_EN == 0 && int'(idx) == DECOMP_IDX)) begin
            tgt = TGT_W'(idx);
        end
        tgt_is_port = (tgt != ERR_TGT);
    end

    // Response steering from the current target; anything else is spurious.
    always_comb begin
        r_valid_o = 1'b0;
        r_opc_o   = 1'b0;
        r_rdata_o = '0;
        r_id_o    = '0;
        fwd_mask  = '0;
        if (cnt != '0) begin
            if (cur_tgt == ERR_TGT) begin
                if (err_pend) begin
                    r_valid_o = 1'b1;
                    r_opc_o   = 1'b1;
                    r_rdata_o = ERR_RDATA;
                    r_id_o    = err_id;
                end
            end else begin
                for (int k = 0; k < NB_SLAVES; k++) begin
                    if (cur_tgt == TGT_W'(k)) begin
                        fwd_mask[k] = 1'b1;
                        if (per_r_valid_i[k]) begin
                            r_valid_o = 1'b1;
                            r_opc_o   = per_r_opc_i[k];
                            r_rdata_o = per_r_rdata_i[32*k +: 32];
                            r_id_o    = per_r_id_i[ID_WIDTH*k +: ID_WIDTH];
                        end
                    end
                end
            end
        end
        spurious_evt = |(per_r_valid_i & ~fwd_mask);
    end

    // Admission and request routing; a retiring response frees its slot
    // in the same cycle, so accept looks at the post-decrement count.
    always_comb begin
        cnt_eff   = r_valid_o ? cnt - CNT_W'(1) : cnt;
        accept    = (cnt_eff == '0) || (tgt == cur_tgt && cnt_eff < CNT_MAX);
        per_req_o = '0;
        gnt_o     = 1'b0;
        if (tgt_is_port) begin
            for (int k = 0; k < NB_SLAVES; k++) begin
                if (tgt == TGT_W'(k)) begin
                    per_req_o[k] = req_i & accept;
                    gnt_o        = req_i & accept & per_gnt_i[k];
                end
            end
        end else begin
            gnt_o = req_i & accept;
        end
        handshake = req_i & gnt_o;
    end

    // Outstanding tracking, error slave response register and sticky flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt        <= '0;
            cur_tgt    <= '0;
            err_pend   <= 1'b0;
            err_id     <= '0;
            spurious_o <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples values from before this clock edge.
            if (handshake) begin
                cur_tgt <= tgt;
            end
            if (handshake && !r_valid_o) begin
                cnt <= cnt + CNT_W'(1);
            end else if (!handshake && r_valid_o) begin
                cnt <= cnt - CNT_W'(1);
            end
            // The error slave always answers exactly one cycle after grant.
            err_pend <= handshake && !tgt_is_port;
            if (handshake && !tgt_is_port) begin
                err_id <= id_i;
            end
            if (spurious_evt) begin
                spurious_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cluster_periph_demux.sv
// Directed bench for cluster_periph_demux. Inputs change on the falling
// edge; outputs are sampled 1 ns later, well away from the rising edge.
module tb_cluster_periph_demux;

    localparam int NB  = 10;
    localparam int IDW = 5;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              req_i;
    logic [31:0]       add_i;
    logic              wen_i;
    logic [31:0]       wdata_i;
    logic [3:0]        be_i;
    logic [IDW-1:0]    id_i;
    logic              gnt_o;
    logic              r_valid_o;
    logic              r_opc_o;
    logic [31:0]       r_rdata_o;
    logic [IDW-1:0]    r_id_o;
    logic [NB-1:0]     per_req_o;
    logic [31:0]       per_add_o;
    logic              per_wen_o;
    logic [31:0]       per_wdata_o;
    logic [3:0]        per_be_o;
    logic [IDW-1:0]    per_id_o;
    logic [NB-1:0]     per_gnt_i;
    logic [NB-1:0]     per_r_valid_i;
    logic [NB-1:0]     per_r_opc_i;
    logic [NB*32-1:0]  per_r_rdata_i;
    logic [NB*IDW-1:0] per_r_id_i;
    logic              spurious_o;

    int total  = 0;
    int passed = 0;

    always #5 clk_i = ~clk_i;

    cluster_periph_demux dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .add_i         (add_i),
        .wen_i         (wen_i),
        .wdata_i       (wdata_i),
        .be_i          (be_i),
        .id_i          (id_i),
        .gnt_o         (gnt_o),
        .r_valid_o     (r_valid_o),
        .r_opc_o       (r_opc_o),
        .r_rdata_o     (r_rdata_o),
        .r_id_o        (r_id_o),
        .per_req_o     (per_req_o),
        .per_add_o     (per_add_o),
        .per_wen_o     (per_wen_o),
        .per_wdata_o   (per_wdata_o),
        .per_be_o      (per_be_o),
        .per_id_o      (per_id_o),
        .per_gnt_i     (per_gnt_i),
        .per_r_valid_i (per_r_valid_i),
        .per_r_opc_i   (per_r_opc_i),
        .per_r_rdata_i (per_r_rdata_i),
        .per_r_id_i    (per_r_id_i),
        .spurious_o    (spurious_o)
    );

    task automatic idle();
        req_i = 1'b0; add_i = '0; wen_i = 1'b0; wdata_i = '0; be_i = '0; id_i = '0;
        per_gnt_i = '0; per_r_valid_i = '0; per_r_opc_i = '0;
        per_r_rdata_i = '0; per_r_id_i = '0;
    endtask

    task automatic request(input logic [31:0] a, input logic [IDW-1:0] id);
        req_i = 1'b1; add_i = a; id_i = id; wen_i = 1'b1; be_i = 4'hF; wdata_i = 32'hCAFE_0000;
    endtask

    task automatic respond(input int k, input logic [31:0] d, input logic [IDW-1:0] id);
        per_r_valid_i[k] = 1'b1;
        per_r_rdata_i[32*k +: 32] = d;
        per_r_id_i[IDW*k +: IDW] = id;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        idle();
        #1;
        total++; if (gnt_o !== 1'b0) $display("FAIL reset_gnt: got %0b want 0", gnt_o); else passed++;
        total++; if (r_valid_o !== 1'b0) $display("FAIL reset_rvalid: got %0b want 0", r_valid_o); else passed++;
        total++; if (r_rdata_o !== 32'h0) $display("FAIL reset_rdata: got %h want 0", r_rdata_o); else passed++;
        total++; if (per_req_o !== 10'b0) $display("FAIL reset_per_req: got %b want 0", per_req_o); else passed++;
        total++; if (spurious_o !== 1'b0) $display("FAIL reset_spurious: got %0b want 0", spurious_o); else passed++;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_timer();
        @(negedge clk_i); idle(); request(32'h400, 5'd3); per_gnt_i[1] = 1'b1; #1;
        total++; if (per_req_o !== 10'b0000000010) $display("FAIL timer_per_req: got %b want 0000000010", per_req_o); else passed++;
        total++; if (gnt_o !== 1'b1) $display("FAIL timer_gnt: got %0b want 1", gnt_o); else passed++;
        total++; if (per_add_o !== 32'h400) $display("FAIL timer_per_add: got %h want 400", per_add_o); else passed++;
        @(negedge clk_i); idle(); #1;
        total++; if (r_valid_o !== 1'b0) $display("FAIL timer_early_rvalid: got %0b want 0", r_valid_o); else passed++;
        @(negedge clk_i); idle(); respond(1, 32'h1234, 5'd3); #1;
        total++; if (r_valid_o !== 1'b1) $display("FAIL timer_rvalid: got %0b want 1", r_valid_o); else passed++;
        total++; if (r_rdata_o !== 32'h1234) $display("FAIL timer_rdata: got %h want 1234", r_rdata_o); else passed++;
        total++; if (r_id_o !== 5'd3) $display("FAIL timer_rid: got %0d want 3", r_id_o); else passed++;
    endtask

    task automatic test_unmapped();
        // Granted only if the timer transaction fully retired.
        @(negedge clk_i); idle(); request(32'h2800, 5'd7); per_gnt_i = '1; #1;
        total++; if (per_req_o !== 10'b0) $display("FAIL unmap_per_req: got %b want 0", per_req_o); else passed++;
        total++; if (gnt_o !== 1'b1) $display("FAIL unmap_gnt: got %0b want 1", gnt_o); else passed++;
        @(negedge clk_i); idle(); #1;
        total++; if (r_valid_o !== 1'b1) $display("FAIL unmap_rvalid: got %0b want 1", r_valid_o); else passed++;
        total++; if (r_opc_o !== 1'b1) $display("FAIL unmap_opc: got %0b want 1", r_opc_o); else passed++;
        total++; if (r_rdata_o !== 32'hBADACCE5) $display("FAIL unmap_rdata: got %h want badacce5", r_rdata_o); else passed++;
        total++; if (r_id_o !== 5'd7) $display("FAIL unmap_rid: got %0d want 7", r_id_o); else passed++;
        @(negedge clk_i); idle(); request(32'h2000, 5'd7); per_gnt_i = '1; #1;
        total++; if (per_req_o !== 10'b0) $display("FAIL decomp_per_req: got %b want 0", per_req_o); else passed++;
        total++; if (gnt_o !== 1'b1) $display("FAIL decomp_gnt: got %0b want 1", gnt_o); else passed++;
        @(negedge clk_i); idle(); #1;
        total++; if (r_valid_o !== 1'b1) $display("FAIL decomp_rvalid: got %0b want 1", r_valid_o); else passed++;
        total++; if (r_opc_o !== 1'b1) $display("FAIL decomp_opc: got %0b want 1", r_opc_o); else passed++;
        total++; if (r_rdata_o !== 32'hBADACCE5) $display("FAIL decomp_rdata: got %h want badacce5", r_rdata_o); else passed++;
        total++; if (r_id_o !== 5'd7) $display("FAIL decomp_rid: got %0d want 7", r_id_o); else passed++;
    endtask

    task automatic test_back_to_back_err();
        @(negedge clk_i); idle(); request(32'h3C00, 5'd1); #1;
        total++; if (gnt_o !== 1'b1) $display("FAIL b2b_gnt0: got %0b want 1", gnt_o); else passed++;
        total++; if (r_valid_o !== 1'b0) $display("FAIL b2b_idle_rvalid: got %0b want 0", r_valid_o); else passed++;
        @(negedge clk_i); idle(); request(32'h2800, 5'd2); #1;
        total++; if (gnt_o !== 1'b1) $display("FAIL b2b_gnt1: got %0b want 1", gnt_o); else passed++;
        total++; if (r_valid_o !== 1'b1 || r_id_o !== 5'd1) $display("FAIL b2b_rsp0: got valid %0b id %0d want 1 id 1", r_valid_o, r_id_o); else passed++;
        @(negedge clk_i); idle(); #1;
        total++; if (r_valid_o !== 1'b1 || r_id_o !== 5'd2) $display("FAIL b2b_rsp1: got valid %0b id %0d want 1 id 2", r_valid_o, r_id_o); else passed++;
        @(negedge clk_i); idle(); #1;
        total++; if (r_valid_o !== 1'b0) $display("FAIL b2b_done: got %0b want 0", r_valid_o); else passed++;
    endtask

    task automatic test_outstanding();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i); idle(); request(32'h0, 5'(i)); per_gnt_i[0] = 1'b1; #1;
            total++; if (gnt_o !== 1'b1) $display("FAIL outst_gnt%0d: got %0b want 1", i, gnt_o); else passed++;
        end
        @(negedge clk_i); idle(); request(32'h0, 5'd4); per_gnt_i[0] = 1'b1; #1;
        total++; if (gnt_o !== 1'b0) $display("FAIL outst_full_gnt: got %0b want 0", gnt_o); else passed++;
        total++; if (per_req_o !== 10'b0) $display("FAIL outst_full_req: got %b want 0", per_req_o); else passed++;
        @(negedge clk_i); idle(); request(32'h0, 5'd4); per_gnt_i[0] = 1'b1; respond(0, 32'hA0, 5'd0); #1;
        total++; if (r_valid_o !== 1'b1 || r_rdata_o !== 32'hA0) $display("FAIL outst_rsp: got valid %0b data %h want 1 a0", r_valid_o, r_rdata_o); else passed++;
        total++; if (gnt_o !== 1'b1) $display("FAIL outst_retire_gnt: got %0b want 1", gnt_o); else passed++;
        @(negedge clk_i); idle(); request(32'h0, 5'd5); per_gnt_i[0] = 1'b1; #1;
        total++; if (gnt_o !== 1'b0) $display("FAIL outst_still_full: got %0b want 0", gnt_o); else passed++;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk_i); idle(); respond(0, 32'hA0 + 32'(i), 5'(i)); #1;
            total++; if (r_valid_o !== 1'b1 || r_id_o !== 5'(i)) $display("FAIL outst_drain%0d: got valid %0b id %0d want 1 id %0d", i, r_valid_o, r_id_o, i); else passed++;
        end
    endtask

    task automatic test_target_switch();
        @(negedge clk_i); idle(); request(32'h1800, 5'd1); per_gnt_i = 10'b0001000000; #1;
        total++; if (gnt_o !== 1'b1) $display("FAIL switch_dma_gnt0: got %0b want 1", gnt_o); else passed++;
        @(negedge clk_i); idle(); request(32'h1800, 5'd2); per_gnt_i = 10'b0001000000; #1;
        total++; if (gnt_o !== 1'b1) $display("FAIL switch_dma_gnt1: got %0b want 1", gnt_o); else passed++;
        @(negedge clk_i); idle(); request(32'h1000, 5'd3); per_gnt_i = 10'b0001010000; #1;
        total++; if (gnt_o !== 1'b0 || per_req_o !== 10'b0) $display("FAIL switch_stall: got gnt %0b req %b want 0 0", gnt_o, per_req_o); else passed++;
        @(negedge clk_i); idle(); request(32'h1000, 5'd3); per_gnt_i = 10'b0001010000; respond(6, 32'h61, 5'd1); #1;
        total++; if (r_valid_o !== 1'b1 || r_id_o !== 5'd1) $display("FAIL switch_rsp0: got valid %0b id %0d want 1 id 1", r_valid_o, r_id_o); else passed++;
        total++; if (gnt_o !== 1'b0) $display("FAIL switch_stall2: got %0b want 0", gnt_o); else passed++;
        @(negedge clk_i); idle(); request(32'h1000, 5'd3); per_gnt_i = 10'b0000010000; respond(6, 32'h62, 5'd2); #1;
        total++; if (r_valid_o !== 1'b1 || r_rdata_o !== 32'h62) $display("FAIL switch_rsp1: got valid %0b data %h want 1 62", r_valid_o, r_rdata_o); else passed++;
        total++; if (gnt_o !== 1'b1 || per_req_o !== 10'b0000010000) $display("FAIL switch_hwpe_gnt: got gnt %0b req %b want 1 0000010000", gnt_o, per_req_o); else passed++;
        @(negedge clk_i); idle(); respond(4, 32'h44, 5'd3); #1;
        total++; if (r_valid_o !== 1'b1 || r_rdata_o !== 32'h44 || r_id_o !== 5'd3) $display("FAIL switch_hwpe_rsp: got valid %0b data %h id %0d want 1 44 3", r_valid_o, r_rdata_o, r_id_o); else passed++;
        @(negedge clk_i); idle(); #1;
        total++; if (spurious_o !== 1'b0) $display("FAIL switch_no_spurious: got %0b want 0", spurious_o); else passed++;
    endtask

    task automatic test_spurious();
        @(negedge clk_i); idle(); respond(5, 32'h55, 5'd3); #1;
        total++; if (r_valid_o !== 1'b0 || r_rdata_o !== 32'h0) $display("FAIL spur_forwarded: got valid %0b data %h want 0 0", r_valid_o, r_rdata_o); else passed++;
        @(negedge clk_i); idle(); #1;
        total++; if (spurious_o !== 1'b1) $display("FAIL spur_set: got %0b want 1", spurious_o); else passed++;
        repeat (3) @(negedge clk_i);
        #1;
        total++; if (spurious_o !== 1'b1) $display("FAIL spur_held: got %0b want 1", spurious_o); else passed++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); idle(); request(32'h0, 5'(i)); per_gnt_i[0] = 1'b1; #1;
            total++; if (gnt_o !== 1'b1) $display("FAIL rstmid_gnt%0d: got %0b want 1", i, gnt_o); else passed++;
        end
        @(negedge clk_i); idle(); per_gnt_i[0] = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        total++; if (gnt_o !== 1'b0 || r_valid_o !== 1'b0 || r_opc_o !== 1'b0) $display("FAIL rstmid_ctrl: got gnt %0b valid %0b opc %0b want 0 0 0", gnt_o, r_valid_o, r_opc_o); else passed++;
        total++; if (r_rdata_o !== 32'h0 || r_id_o !== 5'd0 || per_req_o !== 10'b0) $display("FAIL rstmid_data: got data %h id %0d req %b want 0", r_rdata_o, r_id_o, per_req_o); else passed++;
        total++; if (spurious_o !== 1'b0) $display("FAIL rstmid_spurious: got %0b want 0", spurious_o); else passed++;
        @(negedge clk_i); rst_ni = 1'b1; idle(); respond(0, 32'h77, 5'd0); #1;
        total++; if (r_valid_o !== 1'b0) $display("FAIL rstmid_stale_fwd: got %0b want 0", r_valid_o); else passed++;
        @(negedge clk_i); idle(); #1;
        total++; if (spurious_o !== 1'b1) $display("FAIL rstmid_stale_spur: got %0b want 1", spurious_o); else passed++;
        @(negedge clk_i); idle(); request(32'h1000, 5'd9); per_gnt_i[4] = 1'b1; #1;
        total++; if (gnt_o !== 1'b1 || per_req_o !== 10'b0000010000) $display("FAIL rstmid_first_gnt: got gnt %0b req %b want 1 0000010000", gnt_o, per_req_o); else passed++;
        @(negedge clk_i); idle(); respond(4, 32'h99, 5'd9); #1;
        total++; if (r_valid_o !== 1'b1 || r_id_o !== 5'd9) $display("FAIL rstmid_first_rsp: got valid %0b id %0d want 1 9", r_valid_o, r_id_o); else passed++;
        @(negedge clk_i); idle();
    endtask

    initial begin
        test_reset();
        test_timer();
        test_unmapped();
        test_back_to_back_err();
        test_outstanding();
        test_target_switch();
        test_spurious();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
